// File: rtl/wire_tri_sched.sv
`default_nettype none
// ============================================================================
// Module   : wire_tri_sched
// Brief    : Wireframe triangle scheduler: queues triangles, walks the three
//            edges through one line engine and tags plotted pixels with colour.
// Revision : 1.0 - initial release
// ============================================================================
module wire_tri_sched #(
  parameter int DEPTH   = 4,
  parameter int COLOR_W = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               tri_valid,
  output logic               tri_ready,
  input  logic [31:0]        tri_v0,
  input  logic [31:0]        tri_v1,
  input  logic [31:0]        tri_v2,
  input  logic [COLOR_W-1:0] tri_color,
  input  logic               abort,
  output logic               ln_start,
  output logic [31:0]        ln_p,
  output logic [31:0]        ln_q,
  input  logic [31:0]        ln_point,
  input  logic               ln_plot,
  input  logic               ln_done,
  output logic               pix_valid,
  output logic [31:0]        pix_point,
  output logic [COLOR_W-1:0] pix_color,
  output logic               busy,
  output logic               tri_done
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EDGE  = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_NEXT  = 3'd5,
    S_DRAIN = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0]        r_fifo_v0  [DEPTH];
  logic [31:0]        r_fifo_v1  [DEPTH];
  logic [31:0]        r_fifo_v2  [DEPTH];
  logic [COLOR_W-1:0] r_fifo_col [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;

  logic [31:0]        r_cur_v0;
  logic [31:0]        r_cur_v1;
  logic [31:0]        r_cur_v2;
  logic [COLOR_W-1:0] r_cur_color;
  logic [1:0]         r_edge;
  logic [31:0]        r_ln_p;
  logic [31:0]        r_ln_q;

  logic        w_push;
  logic        w_pop;
  logic        w_ln_start;
  logic        w_tri_done;
  logic [31:0] w_p;
  logic [31:0] w_q;

  // Acceptance depends on occupancy alone, so a full FIFO refuses even while popping.
  assign tri_ready = (r_count < c_DEPTH_CNT);
  assign w_push    = tri_valid & tri_ready & ~abort;
  assign w_pop     = (r_state == S_LOAD) & ~abort;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_v0[r_wr_ptr]  <= tri_v0;
      r_fifo_v1[r_wr_ptr]  <= tri_v1;
      r_fifo_v2[r_wr_ptr]  <= tri_v2;
      r_fifo_col[r_wr_ptr] <= tri_color;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Edge e runs from vertex e to vertex (e+1) mod 3.
  always_comb begin
    w_p = r_cur_v0;
    w_q = r_cur_v1;
    case (r_edge)
      2'd1: begin
        w_p = r_cur_v1;
        w_q = r_cur_v2;
      end
      2'd2: begin
        w_p = r_cur_v2;
        w_q = r_cur_v0;
      end
      default: begin
        w_p = r_cur_v0;
        w_q = r_cur_v1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_IDLE;
      r_cur_v0    <= '0;
      r_cur_v1    <= '0;
      r_cur_v2    <= '0;
      r_cur_color <= '0;
      r_edge      <= 2'd0;
      r_ln_p      <= '0;
      r_ln_q      <= '0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_cur_v0    <= r_fifo_v0[r_rd_ptr];
        r_cur_v1    <= r_fifo_v1[r_rd_ptr];
        r_cur_v2    <= r_fifo_v2[r_rd_ptr];
        r_cur_color <= r_fifo_col[r_rd_ptr];
        r_edge      <= 2'd0;
      end else if ((r_state == S_NEXT) && (r_edge != 2'd2)) begin
        r_edge <= r_edge + 2'd1;
      end
      if ((r_state == S_EDGE) && !abort) begin
        r_ln_p <= w_p;
        r_ln_q <= w_q;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_ln_start = 1'b0;
    w_tri_done = 1'b0;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_next = S_LOAD;
      S_LOAD:  w_next = S_EDGE;
      S_EDGE:  w_next = (w_p == w_q) ? S_NEXT : S_START;
      S_START: begin
        w_ln_start = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT:  if (ln_done) w_next = S_NEXT;
      S_NEXT: begin
        if (r_edge == 2'd2) begin
          w_tri_done = 1'b1;
          w_next     = S_IDLE;
        end else begin
          w_next = S_EDGE;
        end
      end
      S_DRAIN: if (ln_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // A running engine cannot be stopped, so an active line is drained first.
    if (abort) begin
      w_ln_start = 1'b0;
      w_tri_done = 1'b0;
      if ((r_state == S_WAIT) && !ln_done) begin
        w_next = S_DRAIN;
      end else if (r_state == S_DRAIN) begin
        w_next = ln_done ? S_IDLE : S_DRAIN;
      end else begin
        w_next = S_IDLE;
      end
    end
  end

  assign ln_start  = w_ln_start;
  assign ln_p      = r_ln_p;
  assign ln_q      = r_ln_q;
  assign tri_done  = w_tri_done;
  assign pix_valid = ln_plot & (r_state == S_WAIT);
  assign pix_point = ln_point;
  assign pix_color = r_cur_color;
  assign busy      = (r_count != '0) | (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wire_tri_sched.sv
`default_nettype none
// Directed bench for wire_tri_sched: plays the line engine by hand and checks
// edge ordering, FIFO full behaviour, degenerate edges, abort and reset.
module tb_wire_tri_sched;

  logic        clk;
  logic        n_rst;
  logic        tri_valid;
  logic        tri_ready;
  logic [31:0] tri_v0, tri_v1, tri_v2;
  logic [7:0]  tri_color;
  logic        abort;
  logic        ln_start;
  logic [31:0] ln_p, ln_q;
  logic [31:0] ln_point;
  logic        ln_plot;
  logic        ln_done;
  logic        pix_valid;
  logic [31:0] pix_point;
  logic [7:0]  pix_color;
  logic        busy;
  logic        tri_done;

  int checks = 0;
  int errors = 0;
  int n_start = 0;
  int n_pix = 0;
  int n_done = 0;

  wire_tri_sched #(.DEPTH(4), .COLOR_W(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2), .tri_color(tri_color),
    .abort(abort),
    .ln_start(ln_start), .ln_p(ln_p), .ln_q(ln_q),
    .ln_point(ln_point), .ln_plot(ln_plot), .ln_done(ln_done),
    .pix_valid(pix_valid), .pix_point(pix_point), .pix_color(pix_color),
    .busy(busy), .tri_done(tri_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (n_rst) begin
      if (ln_start)  n_start++;
      if (pix_valid) n_pix++;
      if (tri_done)  n_done++;
    end
  end

  function automatic logic [31:0] pt(input int x, input int y);
    return {16'(x), 16'(y)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tri(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [7:0] col);
    int n = 0;
    while (!tri_ready && n < 40) begin
      tick();
      n++;
    end
    chk("push_ready", {31'd0, tri_ready}, 32'd1);
    tri_valid = 1'b1;
    tri_v0 = a; tri_v1 = b; tri_v2 = c; tri_color = col;
    tick();
    tri_valid = 1'b0;
  endtask

  // Waits for ln_start, checks endpoints, then steps into the WAIT cycle.
  task automatic begin_edge(input logic [31:0] p, input logic [31:0] q, output int waited);
    waited = 0;
    while (!ln_start && waited < 40) begin
      tick();
      waited++;
    end
    chk("start_seen", {31'd0, ln_start}, 32'd1);
    chk("ln_p", ln_p, p);
    chk("ln_q", ln_q, q);
    tick();
    chk("start_one_cycle", {31'd0, ln_start}, 32'd0);
  endtask

  task automatic finish_edge(input logic [31:0] p, input int npix, input logic [7:0] col);
    for (int i = 0; i < npix; i++) begin
      ln_plot  = 1'b1;
      ln_point = p + 32'(i);
      #1;
      chk("pix_valid", {31'd0, pix_valid}, 32'd1);
      chk("pix_color", {24'd0, pix_color}, {24'd0, col});
      chk("pix_point", pix_point, p + 32'(i));
      tick();
    end
    ln_plot = 1'b0;
    ln_done = 1'b1;
    tick();
    ln_done = 1'b0;
  endtask

  task automatic run_edge(input logic [31:0] p, input logic [31:0] q,
                          input int npix, input logic [7:0] col);
    int w;
    begin_edge(p, q, w);
    finish_edge(p, npix, col);
  endtask

  task automatic run_tri(input int k);
    logic [31:0] a, b, c;
    a = pt(k, 0); b = pt(k + 10, 0); c = pt(k, 10);
    run_edge(a, b, 1, 8'(8'h10 + k));
    run_edge(b, c, 1, 8'(8'h10 + k));
    run_edge(c, a, 1, 8'(8'h10 + k));
  endtask

  initial begin
    int w, bs, bp, bd;
    n_rst = 1'b0; tri_valid = 1'b0; abort = 1'b0;
    tri_v0 = '0; tri_v1 = '0; tri_v2 = '0; tri_color = '0;
    ln_point = '0; ln_plot = 1'b0; ln_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tri_ready", {31'd0, tri_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ln_start", {31'd0, ln_start}, 32'd0);
    chk("rst_tri_done", {31'd0, tri_done}, 32'd0);
    chk("rst_ln_p", ln_p, 32'd0);
    chk("rst_ln_q", ln_q, 32'd0);
    chk("rst_pix_color", {24'd0, pix_color}, 32'd0);
    chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    n_rst = 1'b1;
    tick();

    // Basic triangle: three edges in order, minimum 3-cycle restart gap.
    bs = n_start; bp = n_pix; bd = n_done;
    push_tri(pt(0, 0), pt(3, 0), pt(0, 3), 8'h5A);
    chk("busy_after_push", {31'd0, busy}, 32'd1);
    run_edge(pt(0, 0), pt(3, 0), 4, 8'h5A);
    begin_edge(pt(3, 0), pt(0, 3), w);
    chk("gap_e1", 32'(w), 32'd2);
    finish_edge(pt(3, 0), 4, 8'h5A);
    begin_edge(pt(0, 3), pt(0, 0), w);
    chk("gap_e2", 32'(w), 32'd2);
    finish_edge(pt(0, 3), 4, 8'h5A);
    chk("tri_done_pulse", {31'd0, tri_done}, 32'd1);
    repeat (3) tick();
    chk("t1_starts", 32'(n_start - bs), 32'd3);
    chk("t1_pixels", 32'(n_pix - bp), 32'd12);
    chk("t1_done", 32'(n_done - bd), 32'd1);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // FIFO fill with the engine stalled on triangle 0.
    push_tri(pt(0, 0), pt(10, 0), pt(0, 10), 8'h10);
    begin_edge(pt(0, 0), pt(10, 0), w);
    for (int k = 1; k <= 4; k++) begin
      tri_valid = 1'b1;
      tri_v0 = pt(k, 0); tri_v1 = pt(k + 10, 0); tri_v2 = pt(k, 10);
      tri_color = 8'(8'h10 + k);
      #1;
      chk("fill_ready", {31'd0, tri_ready}, 32'd1);
      tick();
    end
    tri_v0 = pt(5, 0); tri_v1 = pt(15, 0); tri_v2 = pt(5, 10); tri_color = 8'h15;
    for (int i = 0; i < 3; i++) begin
      chk("full_ready", {31'd0, tri_ready}, 32'd0);
      chk("full_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    tri_valid = 1'b0;
    finish_edge(pt(0, 0), 1, 8'h10);
    run_edge(pt(10, 0), pt(0, 10), 1, 8'h10);
    run_edge(pt(0, 10), pt(0, 0), 1, 8'h10);
    push_tri(pt(5, 0), pt(15, 0), pt(5, 10), 8'h15);
    for (int k = 1; k <= 5; k++) run_tri(k);
    repeat (3) tick();
    chk("fill_drained", {31'd0, busy}, 32'd0);

    // Zero-length first edge, then a fully degenerate triangle.
    bs = n_start; bd = n_done;
    push_tri(pt(2, 2), pt(2, 2), pt(6, 2), 8'h21);
    run_edge(pt(2, 2), pt(6, 2), 2, 8'h21);
    run_edge(pt(6, 2), pt(2, 2), 2, 8'h21);
    repeat (3) tick();
    chk("skip_starts", 32'(n_start - bs), 32'd2);
    chk("skip_done", 32'(n_done - bd), 32'd1);
    bs = n_start; bp = n_pix; bd = n_done;
    push_tri(pt(7, 7), pt(7, 7), pt(7, 7), 8'h22);
    repeat (12) tick();
    chk("degen_starts", 32'(n_start - bs), 32'd0);
    chk("degen_pixels", 32'(n_pix - bp), 32'd0);
    chk("degen_done", 32'(n_done - bd), 32'd1);
    chk("degen_idle", {31'd0, busy}, 32'd0);

    // Abort mid-WAIT with two queued; a push in the abort cycle is dropped.
    push_tri(pt(0, 0), pt(5, 5), pt(0, 5), 8'h33);
    begin_edge(pt(0, 0), pt(5, 5), w);
    push_tri(pt(1, 1), pt(2, 2), pt(3, 1), 8'h34);
    push_tri(pt(4, 4), pt(8, 4), pt(4, 8), 8'h35);
    bs = n_start; bd = n_done;
    ln_plot = 1'b1; ln_point = pt(1, 1);
    #1;
    chk("pre_abort_pix", {31'd0, pix_valid}, 32'd1);
    ln_plot = 1'b0;
    abort = 1'b1;
    tri_valid = 1'b1; tri_v0 = pt(9, 9); tri_v1 = pt(9, 0); tri_v2 = pt(0, 9);
    tick();
    abort = 1'b0; tri_valid = 1'b0;
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_flushed", {31'd0, tri_ready}, 32'd1);
    ln_plot = 1'b1;
    #1;
    chk("drain_pix0", {31'd0, pix_valid}, 32'd0);
    tick();
    chk("drain_pix1", {31'd0, pix_valid}, 32'd0);
    ln_plot = 1'b0;
    ln_done = 1'b1;
    tick();
    ln_done = 1'b0;
    chk("abort_idle", {31'd0, busy}, 32'd0);
    repeat (10) tick();
    chk("abort_no_start", 32'(n_start - bs), 32'd0);
    chk("abort_no_done", 32'(n_done - bd), 32'd0);
    chk("abort_still_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of a line.
    push_tri(pt(0, 0), pt(9, 0), pt(0, 9), 8'h44);
    begin_edge(pt(0, 0), pt(9, 0), w);
    ln_plot = 1'b1;
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, tri_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_pix", {31'd0, pix_valid}, 32'd0);
    chk("mid_rst_ln_p", ln_p, 32'd0);
    chk("mid_rst_ln_q", ln_q, 32'd0);
    chk("mid_rst_color", {24'd0, pix_color}, 32'd0);
    ln_plot = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();
    bs = n_start; bd = n_done;
    push_tri(pt(1, 1), pt(4, 1), pt(1, 5), 8'h3C);
    run_edge(pt(1, 1), pt(4, 1), 2, 8'h3C);
    run_edge(pt(4, 1), pt(1, 5), 2, 8'h3C);
    run_edge(pt(1, 5), pt(1, 1), 2, 8'h3C);
    repeat (3) tick();
    chk("post_rst_starts", 32'(n_start - bs), 32'd3);
    chk("post_rst_done", 32'(n_done - bd), 32'd1);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
